// File: rtl/exp_seq_pkg.sv
// Shared constants for the exposure frame sequencer: register map, reset defaults,
// clamp mask and FSM state encoding.
package exp_seq_pkg;

  localparam int A_NUM_SUB   = 0;
  localparam int A_T_STDBY   = 1;
  localparam int A_T_RESET   = 2;
  localparam int A_TGL_RES   = 3;
  localparam int A_TEXP_CTRL = 4;
  localparam int A_T1        = 5;
  localparam int A_T2        = 6;  // T2..T9 occupy 6..13

  localparam logic [31:0] DEF_NUM_SUB   = 32'd1;
  localparam logic [31:0] DEF_T_STDBY   = 32'd16;
  localparam logic [31:0] DEF_T_RESET   = 32'd8;
  localparam logic [31:0] DEF_TGL_RES   = 32'd4;
  localparam logic [31:0] DEF_TEXP_CTRL = 32'd32;
  localparam logic [31:0] DEF_T1        = 32'd10;
  localparam logic [31:0] DEF_TN        = 32'd5;

  // Registers where a zero would stall the exposure FSM; stored as 1 instead.
  localparam logic [15:0] CLAMP_MASK = 16'h0037;

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_APPLY  = 6'b000010,
    S_ARM    = 6'b000100,
    S_EXPOSE = 6'b001000,
    S_RO_ACK = 6'b010000,
    S_RO_RUN = 6'b100000
  } seq_state_t;

  function automatic logic [31:0] cfg_default(input int idx);
    case (idx)
      A_NUM_SUB:   return DEF_NUM_SUB;
      A_T_STDBY:   return DEF_T_STDBY;
      A_T_RESET:   return DEF_T_RESET;
      A_TGL_RES:   return DEF_TGL_RES;
      A_TEXP_CTRL: return DEF_TEXP_CTRL;
      A_T1:        return DEF_T1;
      default:     return (idx >= A_T2) ? DEF_TN : 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/exp_cfg_bank.sv
// Shadow/active timing register bank: host writes land in the shadow copy, which is
// copied to the active copy on a commit in IDLE or at the APPLY step of a frame.
module exp_cfg_bank
  import exp_seq_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 14
) (
  input  logic             CLKM,
  input  logic             rst,
  input  logic             wr,
  input  logic [3:0]       addr,
  input  logic [DW-1:0]    wdata,
  input  logic             commit,
  input  logic             apply,
  input  logic             idle,
  input  logic             clr_err,
  output logic [NREG*DW-1:0] active_cfg,
  output logic             pending,
  output logic             err
);

  logic [NREG-1:0][DW-1:0] shadow_q, shadow_nxt, active_q;
  logic wr_ok, wr_zero;

  assign wr_ok   = wr && (int'(addr) < NREG);
  assign wr_zero = wr_ok && CLAMP_MASK[addr] && (wdata == '0);

  // Post-write view, so a same-cycle commit captures the new value.
  always_comb begin
    shadow_nxt = shadow_q;
    if (wr_ok) shadow_nxt[addr] = wr_zero ? DW'(1) : wdata;
  end

  always_ff @(posedge CLKM) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= DW'(cfg_default(i));
        active_q[i] <= DW'(cfg_default(i));
      end
      pending <= 1'b0;
      err     <= 1'b0;
    end else begin
      shadow_q <= shadow_nxt;
      if (commit && idle) begin
        active_q <= shadow_nxt;
        pending  <= 1'b0;
      end else begin
        if (apply && pending) active_q <= shadow_q;
        pending <= commit | (pending & ~apply);
      end
      if (wr_zero)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end

  assign active_cfg = active_q;

endmodule

// File: rtl/exp_frame_sequencer.sv
// Frame scheduler: releases one exposure per frame, relays exposure-done to readout,
// counts frames for burst/continuous runs and guards the readout handshake with a timeout.
module exp_frame_sequencer
  import exp_seq_pkg::*;
#(
  parameter int DW         = 32,
  parameter int NREG       = 14,
  parameter int FCNT_W     = 16,
  parameter int RO_TIMEOUT = 2**20
) (
  input  logic               CLKM,
  input  logic               rst,
  input  logic               cfg_wr,
  input  logic [3:0]         cfg_addr,
  input  logic [DW-1:0]      cfg_wdata,
  input  logic               cfg_commit,
  input  logic               start,
  input  logic               stop,
  input  logic [FCNT_W-1:0]  num_frames,
  input  logic               exp_trigger_i,
  input  logic               ro_busy_i,
  output logic               exp_re_busy_o,
  output logic               ro_trigger_o,
  output logic [NREG*DW-1:0] active_cfg,
  output logic               seq_busy,
  output logic [FCNT_W-1:0]  frame_cnt,
  output logic               commit_pending,
  output logic               cfg_err,
  output logic               ro_timeout
);

  localparam int TO_W = $clog2(RO_TIMEOUT) + 1;

  seq_state_t state_q, state_nxt;
  logic              stop_req_q;
  logic [FCNT_W-1:0] nf_q, fcnt_inc;
  logic [TO_W-1:0]   to_cnt_q;
  logic start_ok, in_ro, frame_done, last_frame, to_hit;

  assign start_ok   = start && (state_q == S_IDLE);
  assign in_ro      = (state_q == S_RO_ACK) || (state_q == S_RO_RUN);
  assign frame_done = (state_q == S_RO_RUN) && !ro_busy_i;
  assign fcnt_inc   = frame_cnt + FCNT_W'(1);
  assign last_frame = stop_req_q || ((nf_q != '0) && (fcnt_inc == nf_q));
  // A readout finishing on the last allowed cycle still counts as a completed frame.
  assign to_hit     = in_ro && !frame_done && (to_cnt_q == TO_W'(RO_TIMEOUT - 1));

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:   if (start) state_nxt = S_APPLY;
      S_APPLY:  state_nxt = S_ARM;
      S_ARM:    state_nxt = S_EXPOSE;
      S_EXPOSE: if (exp_trigger_i) state_nxt = S_RO_ACK;
      S_RO_ACK: begin
        if (to_hit)         state_nxt = S_IDLE;
        else if (ro_busy_i) state_nxt = S_RO_RUN;
      end
      S_RO_RUN: begin
        if (frame_done) state_nxt = last_frame ? S_IDLE : S_APPLY;
        else if (to_hit) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLKM) begin
    if (rst) begin
      state_q       <= S_IDLE;
      exp_re_busy_o <= 1'b1;
      ro_trigger_o  <= 1'b0;
      seq_busy      <= 1'b0;
      frame_cnt     <= '0;
      stop_req_q    <= 1'b0;
      nf_q          <= '0;
      to_cnt_q      <= '0;
      ro_timeout    <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      exp_re_busy_o <= (state_nxt != S_ARM);
      ro_trigger_o  <= (state_q == S_EXPOSE) && exp_trigger_i;
      seq_busy      <= (state_nxt != S_IDLE);
      to_cnt_q      <= in_ro ? to_cnt_q + TO_W'(1) : '0;
      if (start_ok) begin
        frame_cnt  <= '0;
        stop_req_q <= 1'b0;
        ro_timeout <= 1'b0;
        nf_q       <= num_frames;
      end else begin
        if (stop && (state_q != S_IDLE)) stop_req_q <= 1'b1;
        if (frame_done) frame_cnt  <= fcnt_inc;
        if (to_hit)     ro_timeout <= 1'b1;
      end
    end
  end

  exp_cfg_bank #(.DW(DW), .NREG(NREG)) u_bank (
    .CLKM       (CLKM),
    .rst        (rst),
    .wr         (cfg_wr),
    .addr       (cfg_addr),
    .wdata      (cfg_wdata),
    .commit     (cfg_commit),
    .apply      (state_q == S_APPLY),
    .idle       (state_q == S_IDLE),
    .clr_err    (start_ok),
    .active_cfg (active_cfg),
    .pending    (commit_pending),
    .err        (cfg_err)
  );

endmodule
